// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state
// encoding, the EBREAK opcode that halts fetch, and the default boot PC.
package rv_fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INSTR_EBREAK     = 32'h0010_0073;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // A fetch target is legal only on a 4-byte boundary.
   function automatic logic is_misaligned(input logic [1:0] byte_offset);
      return byte_offset != 2'b00;
   endfunction

endpackage : rv_fetch_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction and its PC and
// offers it to decode with a valid/ready handshake.
// Priority per edge: flush > load > drain-on-accept > hold.
module if_id_reg #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  flush,
   input  logic                  id_ready,
   input  logic [DATA_WIDTH-1:0] instr_in,
   input  logic [31:0]           pc_in,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [31:0]           if_pc
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [31:0]           pc_q,    pc_d;

   // Next-state selection for the output register.
   always_comb begin
      // NOTE: every signal gets a default before any branch so that no path
      // leaves it unassigned; an unassigned path would infer a latch.
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = instr_in;
         pc_d    = pc_in;
      end else if (valid_q && id_ready) begin
         valid_d = 1'b0;
      end
   end

   // Register update with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign if_valid = valid_q;
   assign if_instr = instr_q;
   assign if_pc    = pc_q;

endmodule : if_id_reg

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, addresses the single-port ROM
// (combinational read), captures each word into the IF/ID register and
// handles redirects, EBREAK halt, misaligned-target fault and an
// accepted-instruction counter.
module imem_fetch_ctrl
   import rv_fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 7,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_q,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [31:0]           if_pc,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  halted,
   output logic                  misalign_err,
   output logic [31:0]           fetch_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         halted_q, halted_d;
   logic         misalign_err_q, misalign_err_d;
   logic [31:0]  fetch_count_q, fetch_count_d;

   logic load;
   logic flush;
   logic accept;
   logic redirect_take;
   logic is_ebreak;

   // The ROM word address is the PC with the byte offset dropped; upper PC
   // bits fall off, so sequential fetch wraps around the ROM.
   assign imem_addr = pc_q[ADDR_WIDTH+1:2];

   // Handshake, load and redirect qualification.
   always_comb begin
      accept        = if_valid && id_ready;
      // Redirects are ignored while booting and once a misaligned target
      // has latched the fault.
      redirect_take = redirect_valid && (state_q != ST_BOOT) && !misalign_err_q;
      // A raw redirect pulse always suppresses the load so that a stale
      // word is never captured on the redirect edge.
      load          = (state_q == ST_RUN) && (!if_valid || id_ready) && !redirect_valid;
      flush         = redirect_take;
      is_ebreak     = (imem_q == DATA_WIDTH'(INSTR_EBREAK));
   end

   // Next PC, FSM state, fault flag and counter.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      misalign_err_d = misalign_err_q;
      fetch_count_d  = fetch_count_q + (accept ? 32'd1 : 32'd0);

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (load && is_ebreak) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_BOOT;
      endcase

      if (load) begin
         pc_d = pc_q + 32'd4;
      end

      // Redirect overrides everything above.
      if (redirect_take) begin
         if (is_misaligned(redirect_pc[1:0])) begin
            misalign_err_d = 1'b1;
            state_d        = ST_HALT;
            pc_d           = pc_q;
         end else begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
         end
      end

      halted_d = (state_d == ST_HALT);
   end

   // Control registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_BOOT;
         pc_q           <= RESET_PC;
         halted_q       <= 1'b0;
         misalign_err_q <= 1'b0;
         fetch_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         halted_q       <= halted_d;
         misalign_err_q <= misalign_err_d;
         fetch_count_q  <= fetch_count_d;
      end
   end

   if_id_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .flush    (flush),
      .id_ready (id_ready),
      .instr_in (imem_q),
      .pc_in    (pc_q),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .if_pc    (if_pc)
   );

   assign halted       = halted_q;
   assign misalign_err = misalign_err_q;
   assign fetch_count  = fetch_count_q;

endmodule : imem_fetch_ctrl
